// File: rtl/if_stage_pkg.sv
// Shared fetch-stage definitions: ISA constants and fetch FSM state encoding.
package if_stage_pkg;

    localparam int unsigned XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats stall; with neither, a missing delivery loads a bubble.
module if_stage_if_id_reg
    import if_stage_pkg::*;
#(
    parameter int unsigned XLEN = if_stage_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            stall,
    input  logic            load,
    input  logic [XLEN-1:0] load_pc,
    input  logic [31:0]     load_instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic [31:0]     instr,
    output logic            valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= '0;
            pc_plus4 <= '0;
            instr    <= NOP_INSTR;
            valid    <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
        end else if (!stall) begin
            if (load) begin
                pc       <= load_pc;
                pc_plus4 <= load_pc + XLEN'(4);
                instr    <= load_instr;
                valid    <= 1'b1;
            end else begin
                // Bubble keeps the PC fields so the last real PC stays visible.
                valid <= 1'b0;
                instr <= NOP_INSTR;
            end
        end
    end

endmodule

// File: rtl/if_stage.sv
// RV32I instruction-fetch stage: PC, single-outstanding imem handshake, hold buffer, IF/ID.
// Optional macro FETCH_PERF_CNT_EN adds fetch/bubble performance counters.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int unsigned     XLEN     = if_stage_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_in,
    input  logic            flush_in,
    input  logic [XLEN-1:0] redirect_pc_in,
    output logic            imem_req_out,
    output logic [XLEN-1:0] imem_addr_out,
    input  logic            imem_rvalid_in,
    input  logic [31:0]     imem_rdata_in,
    output logic [XLEN-1:0] pc_id_out,
    output logic [XLEN-1:0] pc_plus4_id_out,
    output logic [31:0]     instr_id_out,
    output logic            valid_id_out
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     fetch_cnt_out,
    output logic [31:0]     bubble_cnt_out
`endif
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_req_q, pc_req_d;
    logic [31:0]     hold_q, hold_d;
    logic [XLEN-1:0] hold_pc_q, hold_pc_d;

    logic            req;
    logic            deliver;
    logic [XLEN-1:0] deliver_pc;
    logic [31:0]     deliver_instr;
    logic [XLEN-1:0] redirect_pc;

    assign redirect_pc = redirect_pc_in & ALIGN_MASK;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= REQ;
            pc_q      <= RESET_PC & ALIGN_MASK;
            pc_req_q  <= '0;
            hold_q    <= NOP_INSTR;
            hold_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pc_req_q  <= pc_req_d;
            hold_q    <= hold_d;
            hold_pc_q <= hold_pc_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pc_req_d      = pc_req_q;
        hold_d        = hold_q;
        hold_pc_d     = hold_pc_q;
        req           = 1'b0;
        imem_addr_out = pc_q;
        deliver       = 1'b0;
        deliver_pc    = pc_req_q;
        deliver_instr = imem_rdata_in;

        unique case (state_q)
            REQ: begin
                req = !flush_in;
                if (flush_in) begin
                    pc_d = redirect_pc;
                end else begin
                    pc_req_d = pc_q;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                imem_addr_out = pc_req_q + XLEN'(4);
                if (flush_in) begin
                    pc_d    = redirect_pc;
                    state_d = imem_rvalid_in ? REQ : DROP;
                end else if (imem_rvalid_in) begin
                    if (stall_in) begin
                        hold_d    = imem_rdata_in;
                        hold_pc_d = pc_req_q;
                        state_d   = HOLD;
                    end else begin
                        // Deliver and issue the sequential fetch in the same cycle.
                        deliver  = 1'b1;
                        req      = 1'b1;
                        pc_req_d = pc_req_q + XLEN'(4);
                    end
                end
            end
            DROP: begin
                if (flush_in) pc_d = redirect_pc;
                if (imem_rvalid_in) state_d = REQ;
            end
            HOLD: begin
                if (flush_in) begin
                    pc_d    = redirect_pc;
                    state_d = REQ;
                end else if (!stall_in) begin
                    deliver       = 1'b1;
                    deliver_pc    = hold_pc_q;
                    deliver_instr = hold_q;
                    pc_d          = hold_pc_q + XLEN'(4);
                    state_d       = REQ;
                end
            end
            default: state_d = REQ;
        endcase
    end

    assign imem_req_out = req & rst_n;

    if_stage_if_id_reg #(
        .XLEN(XLEN)
    ) u_if_id_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush_in),
        .stall      (stall_in),
        .load       (deliver),
        .load_pc    (deliver_pc),
        .load_instr (deliver_instr),
        .pc         (pc_id_out),
        .pc_plus4   (pc_plus4_id_out),
        .instr      (instr_id_out),
        .valid      (valid_id_out)
    );

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_out  <= '0;
            bubble_cnt_out <= '0;
        end else begin
            if (deliver) fetch_cnt_out <= fetch_cnt_out + 32'd1;
            if (!stall_in && !deliver) bubble_cnt_out <= bubble_cnt_out + 32'd1;
        end
    end
`endif

endmodule
